// File: rtl/rotate_sequencer.sv
// ==== rotate_sequencer : angle tracking, LUT fetch and valid/ready sequencing for the triangle rotator ====
// ==== Revision 1.0 ====
`default_nettype none

module rotate_sequencer #(
    parameter int ANGLE_W     = 8,
    parameter int LUT_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               frame_start_in,
    input  logic [ANGLE_W-1:0] angle_step_in,
    input  logic               tri_valid_in,
    output logic               tri_ready_out,
    input  logic [71:0]        tri_in,
    output logic [ANGLE_W-1:0] lut_addr_out,
    input  logic [15:0]        lut_sin_in,
    input  logic [15:0]        lut_cos_in,
    output logic [71:0]        mul_tri_out,
    output logic [15:0]        mul_sin_out,
    output logic [15:0]        mul_cos_out,
    input  logic [80:0]        mul_res_in,
    output logic               tri_valid_out,
    input  logic               tri_ready_in,
    output logic [80:0]        tri_out,
    output logic [CNT_W-1:0]   tri_count_out,
    output logic               busy_out
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ACCEPT = 2'd1,
        S_CALC   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    localparam logic [3:0] C_LOAD_LAST = 4'(LUT_LATENCY - 1);

    state_t             state_q;
    logic [ANGLE_W-1:0] angle_q;
    logic [ANGLE_W-1:0] angle_d;
    logic [ANGLE_W-1:0] load_angle_q;
    logic               pending_q;
    logic               load_pending_d;
    logic [3:0]         cnt_q;
    logic [71:0]        mul_tri_q;
    logic [15:0]        mul_sin_q;
    logic [15:0]        mul_cos_q;
    logic               tri_valid_q;
    logic [80:0]        tri_q;
    logic [CNT_W-1:0]   count_q;

    always_comb begin
        angle_d = angle_q;
        if (frame_start_in) begin
            angle_d = angle_q + angle_step_in;
        end
    end

    // The first load cycle consumes any earlier request, so only newer frames force a reload.
    always_comb begin
        load_pending_d = frame_start_in;
        if (cnt_q != 4'd0) begin
            load_pending_d = pending_q | frame_start_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q      <= S_LOAD;
            angle_q      <= '0;
            load_angle_q <= '0;
            pending_q    <= 1'b1;
            cnt_q        <= 4'd0;
            mul_tri_q    <= '0;
            mul_sin_q    <= '0;
            mul_cos_q    <= '0;
            tri_valid_q  <= 1'b0;
            tri_q        <= '0;
            count_q      <= '0;
        end else begin
            angle_q <= angle_d;
            if (frame_start_in) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                S_LOAD: begin
                    if (cnt_q == 4'd0) begin
                        pending_q <= frame_start_in;
                    end
                    if (cnt_q == C_LOAD_LAST) begin
                        mul_sin_q <= lut_sin_in;
                        mul_cos_q <= lut_cos_in;
                        cnt_q     <= 4'd0;
                        if (load_pending_d) begin
                            load_angle_q <= angle_d;
                        end else begin
                            state_q <= S_ACCEPT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ACCEPT: begin
                    if (pending_q) begin
                        load_angle_q <= angle_d;
                        state_q      <= S_LOAD;
                    end else if (tri_valid_in) begin
                        mul_tri_q <= tri_in;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    tri_q       <= mul_res_in;
                    tri_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (tri_ready_in) begin
                        tri_valid_q <= 1'b0;
                        if (count_q != '1) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (pending_q || frame_start_in) begin
                            load_angle_q <= angle_d;
                            state_q      <= S_LOAD;
                        end else begin
                            state_q <= S_ACCEPT;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase

            // A new frame clears the count even when an emit lands in the same cycle.
            if (frame_start_in) begin
                count_q <= '0;
            end
        end
    end

    assign tri_ready_out = (state_q == S_ACCEPT) && !pending_q;
    assign busy_out      = (state_q != S_ACCEPT);
    assign lut_addr_out  = load_angle_q;
    assign mul_tri_out   = mul_tri_q;
    assign mul_sin_out   = mul_sin_q;
    assign mul_cos_out   = mul_cos_q;
    assign tri_valid_out = tri_valid_q;
    assign tri_out       = tri_q;
    assign tri_count_out = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
// ==== tb_rotate_sequencer : directed self-checking bench for rotate_sequencer ====
// ==== Revision 1.0 ====
`default_nettype none

module tb_rotate_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in_n;
    logic        frame_start_in;
    logic [7:0]  angle_step_in;
    logic        tri_valid_in;
    logic        tri_ready_out;
    logic [71:0] tri_in;
    logic [7:0]  lut_addr_out;
    logic [15:0] lut_sin_in;
    logic [15:0] lut_cos_in;
    logic [71:0] mul_tri_out;
    logic [15:0] mul_sin_out;
    logic [15:0] mul_cos_out;
    logic [80:0] mul_res_in;
    logic        tri_valid_out;
    logic        tri_ready_in;
    logic [80:0] tri_out;
    logic [15:0] tri_count_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    localparam logic [71:0] c_T1 = 72'h01_02_03_04_05_06_07_08_09;
    localparam logic [71:0] c_T2 = 72'hA1_B2_C3_D4_E5_F6_17_28_39;
    localparam logic [80:0] c_R1 = 81'h0_1234_5678_9ABC_DEF0_1357;
    localparam logic [80:0] c_R2 = 81'h1_FEDC_BA98_7654_3210_2468;

    rotate_sequencer #(.ANGLE_W(8), .LUT_LATENCY(2), .CNT_W(16)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .frame_start_in(frame_start_in),
        .angle_step_in(angle_step_in), .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .tri_in(tri_in), .lut_addr_out(lut_addr_out), .lut_sin_in(lut_sin_in), .lut_cos_in(lut_cos_in),
        .mul_tri_out(mul_tri_out), .mul_sin_out(mul_sin_out), .mul_cos_out(mul_cos_out),
        .mul_res_in(mul_res_in), .tri_valid_out(tri_valid_out), .tri_ready_in(tri_ready_in),
        .tri_out(tri_out), .tri_count_out(tri_count_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // LUT model: one register stage, so data for an address is usable on the second load cycle.
    logic [7:0] lut_addr_d1 = 8'h00;
    always @(posedge clk_in) lut_addr_d1 <= lut_addr_out;
    assign lut_sin_in = {lut_addr_d1, lut_addr_d1};
    assign lut_cos_in = 16'h4000 - {8'h00, lut_addr_d1};

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0; frame_start_in = 0; angle_step_in = 0; tri_valid_in = 0;
        tri_in = '0; mul_res_in = '0; tri_ready_in = 0;
        tick(); tick();
        checks++; if (tri_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", tri_valid_out); end
        checks++; if (tri_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", tri_ready_out); end
        checks++; if (mul_cos_out !== 16'h0000) begin errors++; $display("FAIL rst_cos: got %h expected 0000", mul_cos_out); end
        checks++; if (tri_count_out !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h expected 0000", tri_count_out); end
        rst_in_n = 1'b1;
        #1;
        checks++; if (lut_addr_out !== 8'h00) begin errors++; $display("FAIL load0_addr: got %h expected 00", lut_addr_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL load0_busy: got %b expected 1", busy_out); end
        tick();
        checks++; if (tri_ready_out !== 1'b0) begin errors++; $display("FAIL load1_ready: got %b expected 0", tri_ready_out); end
        checks++; if (lut_addr_out !== 8'h00) begin errors++; $display("FAIL load1_addr: got %h expected 00", lut_addr_out); end
        tick();
        checks++; if (tri_ready_out !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b expected 1", tri_ready_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL accept_busy: got %b expected 0", busy_out); end
        checks++; if (mul_cos_out !== 16'h4000) begin errors++; $display("FAIL init_cos: got %h expected 4000", mul_cos_out); end
        checks++; if (mul_sin_out !== 16'h0000) begin errors++; $display("FAIL init_sin: got %h expected 0000", mul_sin_out); end
    endtask

    task automatic test_single();
        tri_in = c_T1; mul_res_in = c_R1; tri_valid_in = 1; tri_ready_in = 1;
        tick();
        tri_valid_in = 0;
        checks++; if (mul_tri_out !== c_T1) begin errors++; $display("FAIL single_multri: got %h expected %h", mul_tri_out, c_T1); end
        checks++; if (tri_ready_out !== 1'b0) begin errors++; $display("FAIL single_calc_ready: got %b expected 0", tri_ready_out); end
        checks++; if (tri_valid_out !== 1'b0) begin errors++; $display("FAIL single_calc_valid: got %b expected 0", tri_valid_out); end
        tick();
        checks++; if (tri_valid_out !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", tri_valid_out); end
        checks++; if (tri_out !== c_R1) begin errors++; $display("FAIL single_out_data: got %h expected %h", tri_out, c_R1); end
        tick();
        checks++; if (tri_valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", tri_valid_out); end
        checks++; if (tri_count_out !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", tri_count_out); end
        checks++; if (tri_ready_out !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b expected 1", tri_ready_out); end
    endtask

    task automatic test_backpressure();
        tri_in = c_T1; mul_res_in = c_R1; tri_valid_in = 1; tri_ready_in = 0;
        tick();
        tri_in = c_T2;
        tick();
        mul_res_in = c_R2;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tri_out !== c_R1 || tri_valid_out !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got %h/%b expected %h/1", i, tri_out, tri_valid_out, c_R1); end
            checks++; if (tri_ready_out !== 1'b0 || mul_tri_out !== c_T1) begin errors++; $display("FAIL bp_noaccept%0d: got ready %b tri %h expected 0 %h", i, tri_ready_out, mul_tri_out, c_T1); end
            tick();
        end
        tri_ready_in = 1;
        tick();
        tri_ready_in = 0;
        checks++; if (tri_count_out !== 16'd2) begin errors++; $display("FAIL bp_count2: got %0d expected 2", tri_count_out); end
        checks++; if (tri_ready_out !== 1'b1 || mul_tri_out !== c_T1) begin errors++; $display("FAIL bp_drained: got ready %b tri %h expected 1 %h", tri_ready_out, mul_tri_out, c_T1); end
        tick();
        tri_valid_in = 0;
        checks++; if (mul_tri_out !== c_T2) begin errors++; $display("FAIL bp_second: got %h expected %h", mul_tri_out, c_T2); end
        tick();
        checks++; if (tri_out !== c_R2) begin errors++; $display("FAIL bp_second_out: got %h expected %h", tri_out, c_R2); end
        tri_ready_in = 1;
        tick();
        checks++; if (tri_count_out !== 16'd3) begin errors++; $display("FAIL bp_count3: got %0d expected 3", tri_count_out); end
    endtask

    task automatic test_back_to_back();
        tri_in = c_T1; mul_res_in = c_R1; tri_valid_in = 1; tri_ready_in = 1;
        repeat (9) tick();
        tri_valid_in = 0;
        checks++; if (tri_count_out !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", tri_count_out); end
        checks++; if (tri_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", tri_ready_out); end
    endtask

    task automatic test_frame();
        angle_step_in = 8'd3; frame_start_in = 1;
        tick();
        frame_start_in = 0;
        checks++; if (tri_count_out !== 16'd0) begin errors++; $display("FAIL frame1_count: got %0d expected 0", tri_count_out); end
        checks++; if (tri_ready_out !== 1'b0) begin errors++; $display("FAIL frame1_ready: got %b expected 0", tri_ready_out); end
        tick();
        checks++; if (lut_addr_out !== 8'd3 || busy_out !== 1'b1) begin errors++; $display("FAIL frame1_addr: got %0d busy %b expected 3 busy 1", lut_addr_out, busy_out); end
        tick(); tick();
        checks++; if (mul_sin_out !== 16'h0303 || mul_cos_out !== 16'h3FFD) begin errors++; $display("FAIL frame1_lut: got %h/%h expected 0303/3ffd", mul_sin_out, mul_cos_out); end
        checks++; if (tri_ready_out !== 1'b1) begin errors++; $display("FAIL frame1_accept: got %b expected 1", tri_ready_out); end
        // Second frame lands exactly on the output handshake.
        tri_in = c_T2; mul_res_in = c_R2; tri_valid_in = 1; tri_ready_in = 1;
        tick();
        tri_valid_in = 0;
        tick();
        frame_start_in = 1;
        tick();
        frame_start_in = 0;
        checks++; if (tri_count_out !== 16'd0 || tri_valid_out !== 1'b0) begin errors++; $display("FAIL frame2_clear: got count %0d valid %b expected 0 0", tri_count_out, tri_valid_out); end
        checks++; if (lut_addr_out !== 8'd6 || tri_ready_out !== 1'b0) begin errors++; $display("FAIL frame2_addr: got %0d ready %b expected 6 0", lut_addr_out, tri_ready_out); end
        tick(); tick();
        checks++; if (mul_sin_out !== 16'h0606 || mul_cos_out !== 16'h3FFA || tri_ready_out !== 1'b1) begin errors++; $display("FAIL frame2_lut: got %h/%h ready %b expected 0606/3ffa 1", mul_sin_out, mul_cos_out, tri_ready_out); end
    endtask

    task automatic test_frame_in_calc();
        tri_in = c_T1; mul_res_in = c_R1; tri_valid_in = 1; tri_ready_in = 0;
        tick();
        tri_valid_in = 0; frame_start_in = 1;
        tick();
        frame_start_in = 0;
        checks++; if (mul_sin_out !== 16'h0606 || tri_valid_out !== 1'b1 || tri_out !== c_R1) begin errors++; $display("FAIL calc_old_sin: got %h valid %b data %h expected 0606 1 %h", mul_sin_out, tri_valid_out, tri_out, c_R1); end
        tri_ready_in = 1;
        tick();
        checks++; if (tri_count_out !== 16'd1 || tri_ready_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL calc_reload: got count %0d ready %b busy %b expected 1 0 1", tri_count_out, tri_ready_out, busy_out); end
        checks++; if (lut_addr_out !== 8'd9 || mul_sin_out !== 16'h0606) begin errors++; $display("FAIL calc_addr: got %0d sin %h expected 9 0606", lut_addr_out, mul_sin_out); end
        tick(); tick();
        checks++; if (mul_sin_out !== 16'h0909 || tri_ready_out !== 1'b1) begin errors++; $display("FAIL calc_newlut: got %h ready %b expected 0909 1", mul_sin_out, tri_ready_out); end
    endtask

    task automatic test_reset_in_out();
        tri_in = c_T2; mul_res_in = c_R2; tri_valid_in = 1; tri_ready_in = 0;
        tick();
        tri_valid_in = 0;
        tick();
        checks++; if (tri_valid_out !== 1'b1) begin errors++; $display("FAIL rout_pre: got %b expected 1", tri_valid_out); end
        rst_in_n = 0;
        #2;
        checks++; if (tri_valid_out !== 1'b0 || tri_out !== '0 || mul_tri_out !== '0) begin errors++; $display("FAIL rout_clear: got valid %b data %h expected 0 0", tri_valid_out, tri_out); end
        checks++; if (lut_addr_out !== 8'd0 || mul_sin_out !== 16'h0 || busy_out !== 1'b1) begin errors++; $display("FAIL rout_state: got addr %0d sin %h busy %b expected 0 0000 1", lut_addr_out, mul_sin_out, busy_out); end
        tick();
        rst_in_n = 1;
        tick(); tick();
        checks++; if (tri_ready_out !== 1'b1 || mul_cos_out !== 16'h4000) begin errors++; $display("FAIL rout_reload: got ready %b cos %h expected 1 4000", tri_ready_out, mul_cos_out); end
        frame_start_in = 1;
        tick();
        frame_start_in = 0;
        tick();
        checks++; if (lut_addr_out !== 8'd3) begin errors++; $display("FAIL rout_angle: got %0d expected 3", lut_addr_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_frame();
        test_frame_in_calc();
        test_reset_in_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
